// File: rtl/ctle_step_monitor.sv
// ---------------------------------------------------------------------------
// ctle_step_monitor
//
// Observer on the output side of the emulated CTLE path. It watches the
// differential input (in_p - in_n) for steps. When it sees a step it captures
// a fixed window of the differential output (out_p - out_n). It then reports
// four values over a valid/ready handshake:
//   - the output just before the step
//   - the peak excursion
//   - the settled (last) output
//   - the input step size
// One emu_clk cycle corresponds to one 10 ps emulator timestep.
//
// Ports:
//   emu_clk        emulator clock, all state updates on its rising edge
//   emu_rst        synchronous active-high reset
//   in_p, in_n     CTLE differential input, signed WIDTH bits
//   out_p, out_n   CTLE differential output, signed WIDTH bits
//   res_valid      result record available (state REPORT)
//   res_ready      consumer accepts the record when res_valid && res_ready
//   res_din_delta  din after the step minus din before the step
//   res_pre        vod one cycle before detection
//   res_peak       window sample with the largest |vod - res_pre|
//   res_final      last window sample
//   busy           high while capturing or reporting
//   restart_cnt    steps that restarted a capture in progress (saturating)
//   drop_cnt       steps ignored while reporting (saturating)
// ---------------------------------------------------------------------------
module ctle_step_monitor #(
    parameter int WIDTH       = 18,
    parameter int WINDOW      = 90,
    parameter int STEP_THRESH = 256,
    parameter int DROP_W      = 8
) (
    input  logic                    emu_clk,
    input  logic                    emu_rst,
    input  logic signed [WIDTH-1:0] in_p,
    input  logic signed [WIDTH-1:0] in_n,
    input  logic signed [WIDTH-1:0] out_p,
    input  logic signed [WIDTH-1:0] out_n,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [WIDTH:0]   res_din_delta,
    output logic signed [WIDTH:0]   res_pre,
    output logic signed [WIDTH:0]   res_peak,
    output logic signed [WIDTH:0]   res_final,
    output logic                    busy,
    output logic [DROP_W-1:0]       restart_cnt,
    output logic [DROP_W-1:0]       drop_cnt
);

    localparam int              CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);
    localparam logic [WIDTH+1:0] THRESH_V = (WIDTH+2)'(STEP_THRESH);
    localparam logic [DROP_W-1:0] CNT_SAT = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_REPORT  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Registered history and capture state
    logic signed [WIDTH:0]   r_din_q;
    logic signed [WIDTH:0]   r_vod_q;
    logic signed [WIDTH:0]   r_pre;
    logic signed [WIDTH:0]   r_delta;
    logic signed [WIDTH:0]   r_peak;
    logic signed [WIDTH:0]   r_final;
    logic signed [WIDTH:0]   r_max;
    logic signed [WIDTH:0]   r_min;
    logic [CNT_W-1:0]        r_cnt;
    logic [DROP_W-1:0]       r_restart_cnt;
    logic [DROP_W-1:0]       r_drop_cnt;

    // Combinational datapath
    logic signed [WIDTH:0]   w_din;
    logic signed [WIDTH:0]   w_vod;
    logic signed [WIDTH+1:0] w_diff;
    logic [WIDTH+1:0]        w_diff_mag;
    logic                    w_step;
    logic signed [WIDTH:0]   w_max_upd;
    logic signed [WIDTH:0]   w_min_upd;
    logic signed [WIDTH+1:0] w_pos_exc;
    logic signed [WIDTH+1:0] w_neg_exc;
    logic signed [WIDTH:0]   w_peak_sel;

    // FSM strobes
    logic w_start;
    logic w_finish;
    logic w_restart;
    logic w_drop;

    // Sign-extend before subtracting so the difference can never wrap.
    assign w_din = {in_p[WIDTH-1], in_p} - {in_n[WIDTH-1], in_n};
    assign w_vod = {out_p[WIDTH-1], out_p} - {out_n[WIDTH-1], out_n};

    // The step magnitude needs one more bit than din. As an unsigned
    // WIDTH+2 value, the negation of the most negative difference
    // still fits.
    assign w_diff     = {w_din[WIDTH], w_din} - {r_din_q[WIDTH], r_din_q};
    assign w_diff_mag = w_diff[WIDTH+1] ? (~w_diff + 1'b1) : w_diff;
    assign w_step     = (w_diff_mag >= THRESH_V);

    // Extremes including the current sample. The finishing edge needs
    // them, so the peak decision sees the last sample as well.
    assign w_max_upd = (w_vod > r_max) ? w_vod : r_max;
    assign w_min_upd = (w_vod < r_min) ? w_vod : r_min;
    assign w_pos_exc = {w_max_upd[WIDTH], w_max_upd} - {r_pre[WIDTH], r_pre};
    assign w_neg_exc = {r_pre[WIDTH], r_pre} - {w_min_upd[WIDTH], w_min_upd};
    // ">=" makes a tie resolve to the positive extreme.
    assign w_peak_sel = (w_pos_exc >= w_neg_exc) ? w_max_upd : w_min_upd;

    // State register
    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and strobes
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_finish     = 1'b0;
        w_restart    = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_step) begin
                    w_start      = 1'b1;
                    w_state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // A new step restarts the window, even on the last cycle.
                if (w_step) begin
                    w_start   = 1'b1;
                    w_restart = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_finish     = 1'b1;
                    w_state_next = ST_REPORT;
                end
            end
            ST_REPORT: begin
                // A step is dropped here, including on the handshake cycle.
                w_drop = w_step;
                if (res_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath and counters
    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            r_din_q       <= '0;
            r_vod_q       <= '0;
            r_pre         <= '0;
            r_delta       <= '0;
            r_peak        <= '0;
            r_final       <= '0;
            r_max         <= '0;
            r_min         <= '0;
            r_cnt         <= '0;
            r_restart_cnt <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_din_q <= w_din;
            r_vod_q <= w_vod;

            if (w_start) begin
                r_pre   <= r_vod_q;
                // The reported delta keeps the low WIDTH+1 bits of the
                // difference.
                r_delta <= w_diff[WIDTH:0];
                r_cnt   <= '0;
                r_max   <= w_vod;
                r_min   <= w_vod;
            end else if (r_state == ST_CAPTURE) begin
                r_max <= w_max_upd;
                r_min <= w_min_upd;
                r_cnt <= r_cnt + 1'b1;
                if (w_finish) begin
                    r_final <= w_vod;
                    r_peak  <= w_peak_sel;
                end
            end

            if (w_restart && (r_restart_cnt != CNT_SAT)) begin
                r_restart_cnt <= r_restart_cnt + 1'b1;
            end
            if (w_drop && (r_drop_cnt != CNT_SAT)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    // Record fields change only when a capture starts or finishes.
    // Neither happens in REPORT, so the record holds until the handshake.
    assign res_valid     = (r_state == ST_REPORT);
    assign busy          = (r_state != ST_IDLE);
    assign res_din_delta = r_delta;
    assign res_pre       = r_pre;
    assign res_peak      = r_peak;
    assign res_final     = r_final;
    assign restart_cnt   = r_restart_cnt;
    assign drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_ctle_step_monitor.sv
module tb_ctle_step_monitor;

    localparam int WIDTH  = 18;
    localparam int DROP_W = 8;

    logic                    emu_clk;
    logic                    emu_rst;
    logic signed [WIDTH-1:0] in_p;
    logic signed [WIDTH-1:0] in_n;
    logic signed [WIDTH-1:0] out_p;
    logic signed [WIDTH-1:0] out_n;
    logic                    res_valid;
    logic                    res_ready;
    logic signed [WIDTH:0]   res_din_delta;
    logic signed [WIDTH:0]   res_pre;
    logic signed [WIDTH:0]   res_peak;
    logic signed [WIDTH:0]   res_final;
    logic                    busy;
    logic [DROP_W-1:0]       restart_cnt;
    logic [DROP_W-1:0]       drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    ctle_step_monitor #(
        .WIDTH(WIDTH), .WINDOW(90), .STEP_THRESH(256), .DROP_W(DROP_W)
    ) dut (
        .emu_clk(emu_clk), .emu_rst(emu_rst),
        .in_p(in_p), .in_n(in_n), .out_p(out_p), .out_n(out_n),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_din_delta(res_din_delta), .res_pre(res_pre),
        .res_peak(res_peak), .res_final(res_final),
        .busy(busy), .restart_cnt(restart_cnt), .drop_cnt(drop_cnt)
    );

    initial emu_clk = 1'b0;
    always #5 emu_clk = ~emu_clk;

    task automatic tick();
        @(posedge emu_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int vod_at(int j, int v0, int pk, int rl, int fin);
        if (j == 0) return v0;
        if (j <= rl) return v0 + ((pk - v0) * j) / rl;
        return fin;
    endfunction

    // Walk in_p/in_n to a target in moves of at most 100 LSB each.
    // Each din change is then at most 200, below the step threshold.
    task automatic glide(input int tp, input int tn);
        int cp;
        int cn;
        out_p = '0;
        out_n = '0;
        for (int k = 0; k < 1000; k++) begin
            cp = int'(in_p);
            cn = int'(in_n);
            if (cp == tp && cn == tn) break;
            if (cp < tp) cp = (tp - cp > 100) ? cp + 100 : tp;
            else if (cp > tp) cp = (cp - tp > 100) ? cp - 100 : tp;
            if (cn < tn) cn = (tn - cn > 100) ? cn + 100 : tn;
            else if (cn > tn) cn = (cn - tn > 100) ? cn - 100 : tn;
            in_p = WIDTH'(cp);
            in_n = WIDTH'(cn);
            tick();
        end
        repeat (3) tick();
    endtask

    // Apply a step, then drive the vod profile one sample per edge.
    // Returns the number of edges, counting the detection edge, until
    // res_valid is seen, or max_ticks edges if it never appears.
    task automatic run_capture(input int p, input int n, input int v0,
                               input int pk, input int rl, input int fin,
                               input int max_ticks, output int edges,
                               output bit seen);
        edges = 0;
        seen  = 1'b0;
        in_p  = WIDTH'(p);
        in_n  = WIDTH'(n);
        out_p = WIDTH'(v0 + int'(out_n));
        for (int j = 0; j < max_ticks; j++) begin
            tick();
            edges++;
            if (res_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            out_p = WIDTH'(vod_at(j + 1, v0, pk, rl, fin) + int'(out_n));
        end
    endtask

    initial begin
        int  edges;
        bit  seen;
        int  bad;

        emu_rst   = 1'b1;
        in_p      = '0;
        in_n      = '0;
        out_p     = '0;
        out_n     = '0;
        res_ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_restart", restart_cnt, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_pre", res_pre, 0);
        emu_rst = 1'b0;

        // Quiet idle period
        bad = 0;
        repeat (500) begin
            tick();
            if (res_valid !== 1'b0 || busy !== 1'b0 || restart_cnt !== 0 || drop_cnt !== 0) bad++;
        end
        chk("idle_quiet", bad, 0);
        $display("idle 500 cycles: bad=%0d", bad);

        // Positive step with overshoot
        run_capture(1000, 0, 0, 3000, 20, 2000, 200, edges, seen);
        chk("A_seen", seen, 1);
        chk("A_latency", edges, 91);
        chk("A_delta", res_din_delta, 1000);
        chk("A_pre", res_pre, 0);
        chk("A_peak", res_peak, 3000);
        chk("A_final", res_final, 2000);
        $display("A record: delta=%0d pre=%0d peak=%0d final=%0d edges=%0d",
                 res_din_delta, res_pre, res_peak, res_final, edges);
        tick();
        chk("A_valid_drop", res_valid, 0);
        bad = 0;
        repeat (30) begin
            tick();
            if (res_valid !== 1'b0) bad++;
        end
        chk("A_single_record", bad, 0);

        // Negative step through in_n; vod built with a nonzero out_n
        glide(500, 500);
        chk("glide_no_step", busy, 0);
        out_p = 18'sd1000;
        out_n = 18'sd1000;
        tick();
        run_capture(500, 1500, 0, -2500, 20, -1800, 200, edges, seen);
        chk("B_seen", seen, 1);
        chk("B_latency", edges, 91);
        chk("B_delta", res_din_delta, -1000);
        chk("B_pre", res_pre, 0);
        chk("B_peak", res_peak, -2500);
        chk("B_final", res_final, -1800);
        $display("B record: delta=%0d pre=%0d peak=%0d final=%0d",
                 res_din_delta, res_pre, res_peak, res_final);
        tick();

        // Threshold boundary: 255 ignored, 256 detected; equal excursions
        glide(0, 0);
        in_p = 18'sd255;
        repeat (3) tick();
        chk("thr255_ignored", busy, 0);
        run_capture(511, 0, -700, 700, 1, 100, 200, edges, seen);
        chk("T_seen", seen, 1);
        chk("T_delta", res_din_delta, 256);
        chk("T_peak_tie", res_peak, 700);
        chk("T_final", res_final, 100);
        $display("T record: delta=%0d peak=%0d final=%0d",
                 res_din_delta, res_peak, res_final);
        tick();

        // Two steps 40 cycles apart: the record follows the second step
        glide(0, 0);
        run_capture(1000, 0, 400, 400, 0, 400, 40, edges, seen);
        chk("R_no_early", seen, 0);
        run_capture(2000, 0, 400, 1500, 1, 1200, 200, edges, seen);
        chk("R_seen", seen, 1);
        chk("R_latency", edges, 91);
        chk("R_delta", res_din_delta, 1000);
        chk("R_pre", res_pre, 400);
        chk("R_peak", res_peak, 1500);
        chk("R_final", res_final, 1200);
        chk("R_restart", restart_cnt, 1);
        chk("R_drop", drop_cnt, 0);
        $display("R record: delta=%0d pre=%0d peak=%0d final=%0d restart=%0d",
                 res_din_delta, res_pre, res_peak, res_final, restart_cnt);
        tick();

        // Back-pressure: steps during REPORT are dropped, record holds
        glide(0, 0);
        res_ready = 1'b0;
        run_capture(1000, 0, 800, 800, 0, 800, 200, edges, seen);
        chk("D_seen", seen, 1);
        chk("D_latency", edges, 91);
        bad = 0;
        for (int s = 1; s <= 3; s++) begin
            in_p  = WIDTH'(1000 + 1000 * s);
            out_p = WIDTH'(50 * s);
            repeat (5) begin
                tick();
                if (res_valid !== 1'b1 || res_pre !== 0 || res_peak !== 800 ||
                    res_final !== 800 || res_din_delta !== 1000) bad++;
            end
        end
        chk("D_record_held", bad, 0);
        chk("D_drop3", drop_cnt, 3);
        $display("D hold: bad=%0d drop=%0d", bad, drop_cnt);
        res_ready = 1'b1;
        in_p      = 18'sd5000;
        tick();
        chk("D_hs_valid", res_valid, 0);
        chk("D_hs_busy", busy, 0);
        chk("D_drop_hs", drop_cnt, 4);
        run_capture(6000, 0, 300, 300, 0, 300, 200, edges, seen);
        chk("D_next_seen", seen, 1);
        chk("D_next_latency", edges, 91);
        chk("D_next_delta", res_din_delta, 1000);
        chk("D_next_pre", res_pre, 150);
        chk("D_next_peak", res_peak, 300);
        $display("D next record: delta=%0d pre=%0d peak=%0d final=%0d",
                 res_din_delta, res_pre, res_peak, res_final);
        tick();

        // Reset in the middle of a capture
        glide(0, 0);
        run_capture(1000, 0, 500, 500, 0, 500, 50, edges, seen);
        chk("X_capturing", busy, 1);
        emu_rst = 1'b1;
        in_p    = '0;
        out_p   = '0;
        tick();
        emu_rst = 1'b0;
        chk("X_busy", busy, 0);
        chk("X_valid", res_valid, 0);
        chk("X_restart", restart_cnt, 0);
        chk("X_drop", drop_cnt, 0);
        chk("X_pre_clr", res_pre, 0);
        chk("X_peak_clr", res_peak, 0);
        bad = 0;
        repeat (150) begin
            tick();
            if (res_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("X_no_record", bad, 0);
        run_capture(1000, 0, 0, 900, 5, 600, 200, edges, seen);
        chk("X2_seen", seen, 1);
        chk("X2_latency", edges, 91);
        chk("X2_delta", res_din_delta, 1000);
        chk("X2_pre", res_pre, 0);
        chk("X2_peak", res_peak, 900);
        chk("X2_final", res_final, 600);
        chk("X2_restart", restart_cnt, 0);
        chk("X2_drop", drop_cnt, 0);
        $display("X2 record: delta=%0d pre=%0d peak=%0d final=%0d",
                 res_din_delta, res_pre, res_peak, res_final);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ctle_step_monitor.md
Name: ctle_step_monitor

Overview:
- Synthesizable observer on the output side of the emulated CTLE path. It is the reader that pairs with the differential step stimulus.
- Watches the differential input (in_p - in_n) for steps. On each detected step it captures a fixed-length window of the differential output (out_p - out_n), then reports four values: pre-step output, peak excursion, settled output and input step size.
- Results go out over a valid/ready handshake to the emulator readout logic.
- Runs on the emulator clock. One emu_clk cycle equals one DT_MSDSL timestep (10 ps).

Parameters:
- WIDTH, 18: signed fixed-point width of in_p/in_n/out_p/out_n. All four share one binary point.
- WINDOW, 90: capture length in emu_clk cycles. Legal range 2..65535.
- STEP_THRESH, 256: minimum |din - din_q| (in LSBs) that counts as a step. Must be greater than 0.
- DROP_W, 8: width of the dropped-step counter.

Ports:
- emu_clk  in  1  emulator clock; all state updates on rising edge
- emu_rst  in  1  synchronous, active-high reset
- in_p  in  WIDTH  CTLE positive input, signed
- in_n  in  WIDTH  CTLE negative input, signed
- out_p  in  WIDTH  CTLE positive output, signed
- out_n  in  WIDTH  CTLE negative output, signed
- res_valid  out  1  result record available
- res_ready  in  1  consumer accepts record when res_valid && res_ready
- res_din_delta  out  WIDTH+1  din after step minus din before step
- res_pre  out  WIDTH+1  vod one cycle before detection
- res_peak  out  WIDTH+1  window sample with largest |vod - res_pre|
- res_final  out  WIDTH+1  last window sample
- busy  out  1  high in CAPTURE or REPORT
- restart_cnt  out  DROP_W  steps that restarted an in-progress capture; saturating
- drop_cnt  out  DROP_W  steps ignored while in REPORT; saturating

Behaviour:
- Arithmetic:
  - din = in_p - in_n and vod = out_p - out_n, both sign-extended to WIDTH+1. No overflow is possible.
  - din_q and vod_q are copies of din and vod registered every cycle in every state.
  - step = |din - din_q| >= STEP_THRESH. The magnitude is computed at WIDTH+2 bits.
- Reset:
  - State goes to IDLE.
  - res_valid=0, busy=0. All res_* outputs, counters, din_q and vod_q are cleared to 0.
  - Reset mid-CAPTURE or mid-REPORT discards the record without asserting res_valid.
- State IDLE:
  - On step at edge E0: pre<=vod_q, delta<=din-din_q, cnt<=0, max<=min<=vod, go to CAPTURE.
- State CAPTURE, each edge:
  - Update max/min with vod and increment cnt.
  - When cnt==WINDOW-1 at edge E_WINDOW: final<=vod; peak<=(max-pre >= pre-min) ? max : min, where max/min include this cycle's vod; go to REPORT.
  - res_valid is high starting the cycle after E_WINDOW.
- Step during CAPTURE:
  - Abort the current window and restart exactly as if from IDLE, using the new pre, delta and sample.
  - restart_cnt increments, saturating at all-ones.
  - If this coincides with cnt==WINDOW-1, the restart wins and no record is produced.
- State REPORT:
  - res_valid=1. The res_* outputs hold stable until the handshake completes.
  - On res_valid && res_ready: return to IDLE; res_valid=0 on the next cycle.
  - A step in REPORT is not captured. drop_cnt increments, saturating.
  - A step in the same cycle as the handshake is also dropped.
  - A step can be detected in the first IDLE cycle after the handshake.
- Tie rule for peak: when the excursions are equal, the positive extreme is chosen.
- res_ready may be held high permanently. Throughput is then one record per WINDOW+2 cycles minimum.
- busy = (state != IDLE).

Test Plan:
- Reset then idle with constant din=0, vod=0 for 500 cycles -> res_valid, busy, restart_cnt and drop_cnt all stay 0.
- din steps 0->+1000 LSB. vod = 0 before, ramps to 3000 over 20 cycles, then settles to 2000; res_ready=1 -> exactly one record with res_valid first high 91 cycles after detection edge; res_din_delta=1000, res_pre=0, res_peak=3000, res_final=2000.
- din step of -1000 LSB; vod undershoots to -2500 and settles at -1800 -> res_peak=-2500, res_final=-1800, res_din_delta=-1000.
- Two steps 40 cycles apart, WINDOW=90 -> one record, referenced to the second step; restart_cnt=1.
- res_ready=0 after a record; three further steps arrive; then res_ready=1 -> the original record is unchanged throughout; drop_cnt=3; the next step after the handshake is captured.
- emu_rst asserted at cycle 50 of CAPTURE -> busy=0 next cycle, no record ever; a subsequent step produces a normal record with counters at 0.
